// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman encoder/decoder pair: symbol codes,
// decoder state encoding and default code-register width.
package huffman_pkg;

  localparam logic [2:0] A1    = 3'd1;
  localparam logic [2:0] A2    = 3'd2;
  localparam logic [2:0] A3    = 3'd3;
  localparam logic [2:0] A4    = 3'd4;
  localparam logic [2:0] A5    = 3'd5;
  localparam logic [2:0] A6    = 3'd6;
  localparam logic [2:0] GROUP = 3'd7;

  localparam int NUM_CODES   = 6;
  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W       = 4;
  localparam int CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DECODE,
    ST_DONE,
    ST_ERR
  } dec_state_t;

endpackage

// File: rtl/huffman_code_match.sv
// Combinational codeword matcher: compares the candidate accumulator against
// all six table entries and returns the lowest-index hit as a symbol value.
module huffman_code_match
  import huffman_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic [MAX_LEN-1:0]                acc_n,
  input  logic [LEN_W-1:0]                  len_n,
  input  logic [NUM_CODES-1:0][MAX_LEN-1:0] hc,
  input  logic [NUM_CODES-1:0][MAX_LEN-1:0] m,
  output logic                              hit,
  output logic [2:0]                        idx
);

  logic [NUM_CODES-1:0][LEN_W-1:0] code_len;

  // Scan from the highest entry down so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    idx      = 3'd0;
    code_len = '0;
    for (int i = NUM_CODES - 1; i >= 0; i--) begin
      for (int b = 0; b < MAX_LEN; b++) begin
        code_len[i] = code_len[i] + LEN_W'(m[i][b]);
      end
      if (((acc_n & m[i]) == (hc[i] & m[i])) && (len_n == code_len[i])) begin
        hit = 1'b1;
        idx = 3'(i + 1);
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: latches and validates a code table, then turns one
// accepted bit per cycle into symbol pulses until NUM_SYM symbols are out.
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int NUM_SYM = 100,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               code_valid,
  input  logic [MAX_LEN-1:0] HC1,
  input  logic [MAX_LEN-1:0] HC2,
  input  logic [MAX_LEN-1:0] HC3,
  input  logic [MAX_LEN-1:0] HC4,
  input  logic [MAX_LEN-1:0] HC5,
  input  logic [MAX_LEN-1:0] HC6,
  input  logic [MAX_LEN-1:0] M1,
  input  logic [MAX_LEN-1:0] M2,
  input  logic [MAX_LEN-1:0] M3,
  input  logic [MAX_LEN-1:0] M4,
  input  logic [MAX_LEN-1:0] M5,
  input  logic [MAX_LEN-1:0] M6,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               bit_ready,
  output logic               sym_valid,
  output logic [2:0]         sym,
  output logic               done,
  output logic               err
);

  dec_state_t                       state, state_nx;
  logic [NUM_CODES-1:0][MAX_LEN-1:0] hc_q, m_q;
  logic [MAX_LEN-1:0]               acc, acc_n;
  logic [LEN_W-1:0]                 len, len_n;
  logic [CNT_W-1:0]                 cnt;
  logic                             accept, hit, tbl_ok, last_sym, overflow;
  logic [2:0]                       idx;

  assign bit_ready = (state == ST_DECODE);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_ERR);
  assign accept    = bit_valid && bit_ready;
  assign acc_n     = acc | (MAX_LEN'(bit_in) << len);
  assign len_n     = len + LEN_W'(1);
  assign last_sym  = (cnt == CNT_W'(NUM_SYM - 1));
  assign overflow  = (len_n == LEN_W'(MAX_LEN));

  huffman_code_match #(
    .MAX_LEN(MAX_LEN)
  ) u_match (
    .acc_n(acc_n),
    .len_n(len_n),
    .hc   (hc_q),
    .m    (m_q),
    .hit  (hit),
    .idx  (idx)
  );

  // A mask is valid when nonzero and made of contiguous low ones.
  always_comb begin
    tbl_ok = 1'b1;
    for (int i = 0; i < NUM_CODES; i++) begin
      if ((m_q[i] == '0) || ((m_q[i] & (m_q[i] + MAX_LEN'(1))) != '0)) begin
        tbl_ok = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (code_valid) state_nx = ST_CHECK;
      ST_CHECK:  state_nx = tbl_ok ? ST_DECODE : ST_ERR;
      ST_DECODE: begin
        if (accept) begin
          if (hit) begin
            if (last_sym) state_nx = ST_DONE;
          end else if (overflow) begin
            state_nx = ST_ERR;
          end
        end
      end
      ST_DONE:   state_nx = ST_DONE;
      ST_ERR:    state_nx = ST_ERR;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hc_q      <= '0;
      m_q       <= '0;
      acc       <= '0;
      len       <= '0;
      cnt       <= '0;
      sym       <= 3'd0;
      sym_valid <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      if ((state == ST_IDLE) && code_valid) begin
        hc_q <= {HC6, HC5, HC4, HC3, HC2, HC1};
        m_q  <= {M6, M5, M4, M3, M2, M1};
      end
      if (accept) begin
        if (hit) begin
          sym       <= idx;
          sym_valid <= 1'b1;
          acc       <= '0;
          len       <= '0;
          cnt       <= cnt + CNT_W'(1);
        end else if (overflow) begin
          acc <= '0;
          len <= '0;
        end else begin
          acc <= acc_n;
          len <= len_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder using the reference table T and a small
// symbol budget so the DONE path is reachable.
module tb_huffman_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] hc [6];
  logic [7:0] m  [6];
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready;
  logic       sym_valid;
  logic [2:0] sym;
  logic       done;
  logic       err;

  int compares = 0;
  int fails    = 0;

  always #5 clk = ~clk;

  huffman_decoder #(
    .NUM_SYM(4),
    .MAX_LEN(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .code_valid(code_valid),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(m[0]),   .M2(m[1]),   .M3(m[2]),   .M4(m[3]),   .M5(m[4]),   .M6(m[5]),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_ready (bit_ready),
    .sym_valid (sym_valid),
    .sym       (sym),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    compares++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_table_t();
    hc[0] = 8'h01; m[0] = 8'h01;
    hc[1] = 8'h00; m[1] = 8'h03;
    hc[2] = 8'h02; m[2] = 8'h07;
    hc[3] = 8'h06; m[3] = 8'h0F;
    hc[4] = 8'h0E; m[4] = 8'h1F;
    hc[5] = 8'h1E; m[5] = 8'h1F;
  endtask

  task automatic do_reset();
    reset = 1'b1; code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // code_valid for one edge, then the CHECK edge.
  task automatic load_table();
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic v, input logic b);
    bit_valid = v; bit_in = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  // Send one bit and check the symbol pulse that follows it.
  task automatic bit_chk(input string tag, input logic v, input logic b,
                         input logic exp_sv, input logic [2:0] exp_sym);
    cyc(v, b);
    check({tag, "_sv"}, {7'd0, sym_valid}, {7'd0, exp_sv});
    if (exp_sv) check({tag, "_sym"}, {5'd0, sym}, {5'd0, exp_sym});
  endtask

  initial begin
    set_table_t();
    do_reset();
    check("rst_ready", {7'd0, bit_ready}, 8'd0);
    check("rst_sv",    {7'd0, sym_valid}, 8'd0);
    check("rst_sym",   {5'd0, sym},       8'd0);
    check("rst_done",  {7'd0, done},      8'd0);
    check("rst_err",   {7'd0, err},       8'd0);

    // Single-bit code then a two-bit code
    load_table();
    check("t1_ready", {7'd0, bit_ready}, 8'd1);
    bit_chk("t1_b1", 1'b1, 1'b1, 1'b1, 3'd1);
    bit_chk("t1_b2", 1'b1, 1'b0, 1'b0, 3'd0);
    bit_chk("t1_b3", 1'b1, 1'b0, 1'b1, 3'd2);

    // Longer codes with idle gaps mid-code
    do_reset();
    load_table();
    bit_chk("t2_a0", 1'b1, 1'b0, 1'b0, 3'd0);
    bit_chk("t2_gap0", 1'b0, 1'b1, 1'b0, 3'd0);
    bit_chk("t2_a1", 1'b1, 1'b1, 1'b0, 3'd0);
    bit_chk("t2_a2", 1'b1, 1'b0, 1'b1, 3'd3);
    bit_chk("t2_b0", 1'b1, 1'b0, 1'b0, 3'd0);
    bit_chk("t2_b1", 1'b1, 1'b1, 1'b0, 3'd0);
    bit_chk("t2_gap1", 1'b0, 1'b0, 1'b0, 3'd0);
    bit_chk("t2_gap2", 1'b0, 1'b0, 1'b0, 3'd0);
    bit_chk("t2_b2", 1'b1, 1'b1, 1'b0, 3'd0);
    bit_chk("t2_b3", 1'b1, 1'b1, 1'b0, 3'd0);
    bit_chk("t2_b4", 1'b1, 1'b1, 1'b1, 3'd6);
    bit_chk("t2_c0", 1'b1, 1'b0, 1'b0, 3'd0);
    bit_chk("t2_c1", 1'b1, 1'b1, 1'b0, 3'd0);
    bit_chk("t2_c2", 1'b1, 1'b1, 1'b0, 3'd0);
    bit_chk("t2_c3", 1'b1, 1'b0, 1'b1, 3'd4);
    check("t2_done", {7'd0, done}, 8'd0);

    // Back-to-back one-bit codes up to the symbol budget
    do_reset();
    load_table();
    for (int i = 0; i < 3; i++) begin
      bit_chk($sformatf("t3_p%0d", i), 1'b1, 1'b1, 1'b1, 3'd1);
      check($sformatf("t3_done%0d", i),  {7'd0, done},      8'd0);
      check($sformatf("t3_ready%0d", i), {7'd0, bit_ready}, 8'd1);
    end
    bit_chk("t3_p3", 1'b1, 1'b1, 1'b1, 3'd1);
    check("t3_done3",  {7'd0, done},      8'd1);
    check("t3_ready3", {7'd0, bit_ready}, 8'd0);
    bit_chk("t3_p4", 1'b1, 1'b1, 1'b0, 3'd0);
    check("t3_done4", {7'd0, done}, 8'd1);
    // A new table strobe in DONE must not restart anything
    code_valid = 1'b1;
    bit_chk("t3_cv", 1'b0, 1'b0, 1'b0, 3'd0);
    code_valid = 1'b0;
    check("t3_cv_done", {7'd0, done}, 8'd1);

    // Non-contiguous mask
    do_reset();
    m[2] = 8'h05;
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
    check("t4_err_chk", {7'd0, err}, 8'd0);
    @(posedge clk); #1;
    check("t4_err",   {7'd0, err},       8'd1);
    check("t4_ready", {7'd0, bit_ready}, 8'd0);
    bit_chk("t4_bit", 1'b1, 1'b1, 1'b0, 3'd0);
    check("t4_err2", {7'd0, err}, 8'd1);

    // Undecodable stream runs to MAX_LEN
    do_reset();
    set_table_t();
    hc[5] = 8'h3E; m[5] = 8'h3F;
    load_table();
    check("t5_ready", {7'd0, bit_ready}, 8'd1);
    begin
      logic [7:0] pat;
      pat = 8'b0001_1110;
      for (int i = 0; i < 7; i++) begin
        bit_chk($sformatf("t5_b%0d", i), 1'b1, pat[i], 1'b0, 3'd0);
        check($sformatf("t5_err%0d", i), {7'd0, err}, 8'd0);
      end
      bit_chk("t5_b7", 1'b1, pat[7], 1'b0, 3'd0);
    end
    check("t5_err7",   {7'd0, err},       8'd1);
    check("t5_ready7", {7'd0, bit_ready}, 8'd0);

    // Reset mid-code, then reload and decode cleanly
    do_reset();
    set_table_t();
    load_table();
    bit_chk("t6_b0", 1'b1, 1'b0, 1'b0, 3'd0);
    bit_chk("t6_b1", 1'b1, 1'b1, 1'b0, 3'd0);
    reset = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bit_valid = 1'b0;
    check("t6_ready", {7'd0, bit_ready}, 8'd0);
    check("t6_sv",    {7'd0, sym_valid}, 8'd0);
    check("t6_sym",   {5'd0, sym},       8'd0);
    check("t6_done",  {7'd0, done},      8'd0);
    check("t6_err",   {7'd0, err},       8'd0);
    bit_chk("t6_idle", 1'b1, 1'b1, 1'b0, 3'd0);
    check("t6_idle_ready", {7'd0, bit_ready}, 8'd0);
    load_table();
    bit_chk("t6_fresh", 1'b1, 1'b1, 1'b1, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
